// File: rtl/hiscore_ram_bridge_if.sv
// rtl/hiscore_ram_bridge_if.sv - engine, CPU and RAM signal bundle for hiscore_ram_bridge
interface hiscore_ram_bridge_if #(
    parameter int AW = 16
);
    // High-score engine side
    logic [AW-1:0] hs_addr;
    logic [7:0]    hs_din;
    logic          hs_we;
    logic [7:0]    hs_dout;
    logic          hs_busy;
    logic          hs_ovf;

    // Z80 side
    logic          cpu_cs;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_we;

    // Work RAM port
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic [7:0]    ram_rdata;

    modport slave (
        input  hs_addr, hs_din, hs_we,
        input  cpu_cs, cpu_addr, cpu_wdata, cpu_we,
        input  ram_rdata,
        output hs_dout, hs_busy, hs_ovf,
        output ram_addr, ram_wdata, ram_we
    );

    modport master (
        output hs_addr, hs_din, hs_we,
        output cpu_cs, cpu_addr, cpu_wdata, cpu_we,
        output ram_rdata,
        input  hs_dout, hs_busy, hs_ovf,
        input  ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/hiscore_ram_bridge.sv
// rtl/hiscore_ram_bridge.sv - slot-stealing bridge between high-score engine and work RAM
module hiscore_ram_bridge #(
    parameter int AW     = 16,
    parameter int WDEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hiscore_ram_bridge_if.slave  bus
);
    localparam int PW = $clog2(WDEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE
    } state_t;

    state_t        state_q, state_d;

    logic [AW-1:0] prev_addr_q;
    logic [7:0]    prev_din_q;
    logic          prev_we_q;

    logic [AW-1:0] fifo_addr_q [WDEPTH];
    logic [7:0]    fifo_data_q [WDEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q, cnt_d;

    logic          rd_pend_q, rd_pend_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]    dout_q;
    logic          ovf_q;

    logic          wr_req, rd_req;
    logic          fifo_empty, fifo_full;
    logic          can_issue, pop, push, rd_issue, pending_d;

    // Edge/change detect against the previous cycle's engine inputs
    assign wr_req = bus.hs_we && (!prev_we_q || (bus.hs_addr != prev_addr_q)
                                             || (bus.hs_din != prev_din_q));
    assign rd_req = !bus.hs_we && (bus.hs_addr != prev_addr_q);

    // Count reaches WDEPTH (a power of two) exactly when its MSB is set
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = cnt_q[PW];

    assign bus.hs_dout = dout_q;
    assign bus.hs_ovf  = ovf_q;
    assign bus.hs_busy = !fifo_empty || rd_pend_q || (state_q != ST_IDLE);

    // Slot arbitration, buffer bookkeeping and next state
    always_comb begin
        state_d   = state_q;
        can_issue = (state_q != ST_CAPTURE) && !bus.cpu_cs;
        pop       = can_issue && !fifo_empty;
        rd_issue  = can_issue && fifo_empty && rd_pend_q;
        // A pop in the same cycle frees the slot, so a full buffer still accepts
        push      = wr_req && (!fifo_full || pop);

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        if (rd_issue) begin
            rd_pend_d = 1'b0;
        end
        // Newest read request always wins, even over one issuing now
        if (rd_req) begin
            rd_pend_d = 1'b1;
            rd_addr_d = bus.hs_addr;
        end

        pending_d = (cnt_d != '0) || rd_pend_d;

        case (state_q)
            ST_CAPTURE: state_d = pending_d ? ST_ISSUE : ST_IDLE;
            default: begin
                if (rd_issue) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = pending_d ? ST_ISSUE : ST_IDLE;
                end
            end
        endcase
    end

    // RAM port mux: CPU owns the port whenever it selects the RAM
    always_comb begin
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_wdata = bus.cpu_wdata;
        bus.ram_we    = 1'b0;
        if (bus.cpu_cs) begin
            bus.ram_we = bus.cpu_we;
        end else if (pop) begin
            bus.ram_addr  = fifo_addr_q[rd_ptr_q];
            bus.ram_wdata = fifo_data_q[rd_ptr_q];
            bus.ram_we    = 1'b1;
        end else if (rd_issue) begin
            bus.ram_addr = rd_addr_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request history, buffer pointers, pending read and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_addr_q <= '0;
            prev_din_q  <= '0;
            prev_we_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            prev_addr_q <= bus.hs_addr;
            prev_din_q  <= bus.hs_din;
            prev_we_q   <= bus.hs_we;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (wr_req && !push) begin
                ovf_q <= 1'b1;
            end
            if (state_q == ST_CAPTURE) begin
                dout_q <= bus.ram_rdata;
            end
        end
    end

    // Write buffer storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.hs_addr;
            fifo_data_q[wr_ptr_q] <= bus.hs_din;
        end
    end
endmodule

// File: tb/tb_hiscore_ram_bridge.sv
// tb/tb_hiscore_ram_bridge.sv - self-checking bench for hiscore_ram_bridge
module tb_hiscore_ram_bridge;
    localparam int AW     = 16;
    localparam int WDEPTH = 2;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    hiscore_ram_bridge_if #(.AW(AW)) bus ();

    hiscore_ram_bridge #(.AW(AW), .WDEPTH(WDEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [7:0] init_val(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h78;
    endfunction

    // Synchronous work RAM: read data is the pre-write contents of last cycle's address
    logic [7:0] ram     [65536];
    bit         ram_vld [65536];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            ram[bus.ram_addr]     <= bus.ram_wdata;
            ram_vld[bus.ram_addr] <= 1'b1;
        end
        bus.ram_rdata <= ram_vld[bus.ram_addr] ? ram[bus.ram_addr] : init_val(bus.ram_addr);
    end

    function automatic logic [7:0] ram_peek(logic [15:0] a);
        return ram_vld[a] ? ram[a] : init_val(a);
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t         m_wq[$];
    bit          m_rdp, m_cap, m_ovf, m_pwe;
    logic [15:0] m_rda, m_pa;
    logic [7:0]  m_pd, m_dout, m_capd;
    logic [7:0]  mmem [int];

    // Observation logs
    int          bw_cyc[$];
    logic [15:0] bw_addr[$];
    int          br_cnt = 0;
    logic [15:0] br_last = '0;
    logic        o_we, o_busy, o_ovf;
    logic [15:0] o_addr;
    logic [7:0]  o_wd, o_dout;

    function automatic logic [7:0] m_peek(logic [15:0] a);
        return mmem.exists(int'(a)) ? mmem[int'(a)] : init_val(a);
    endfunction

    task automatic model_reset();
        m_wq.delete();
        m_rdp = 0; m_cap = 0; m_ovf = 0; m_pwe = 0;
        m_rda = '0; m_pa = '0; m_pd = '0; m_dout = '0; m_capd = '0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at negedge, compare with model, advance model, step to next edge
    task automatic tick();
        bit          wr_iss, rd_iss, wreq, rreq;
        logic        e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        @(negedge clk);
        o_we = bus.ram_we; o_addr = bus.ram_addr; o_wd = bus.ram_wdata;
        o_dout = bus.hs_dout; o_busy = bus.hs_busy; o_ovf = bus.hs_ovf;

        wr_iss = 0; rd_iss = 0; e_wd = '0;
        if (bus.cpu_cs) begin
            e_addr = bus.cpu_addr; e_we = bus.cpu_we; e_wd = bus.cpu_wdata;
        end else if (!m_cap && m_wq.size() > 0) begin
            wr_iss = 1; e_addr = m_wq[0].a; e_wd = m_wq[0].d; e_we = 1'b1;
        end else if (!m_cap && m_rdp) begin
            rd_iss = 1; e_addr = m_rda; e_we = 1'b0;
        end else begin
            e_addr = bus.cpu_addr; e_we = 1'b0;
        end

        chk("ram_we", o_we, e_we);
        chk("ram_addr", o_addr, e_addr);
        if (e_we) chk("ram_wdata", o_wd, e_wd);
        chk("hs_dout", o_dout, m_dout);
        chk("hs_busy", o_busy, (m_wq.size() > 0) || m_rdp || m_cap);
        chk("hs_ovf", o_ovf, m_ovf);

        if (!bus.cpu_cs && o_we) begin
            bw_cyc.push_back(cyc);
            bw_addr.push_back(o_addr);
        end
        if (!bus.cpu_cs && !o_we && o_addr != bus.cpu_addr) begin
            br_cnt++;
            br_last = o_addr;
        end

        if (m_cap) m_dout = m_capd;
        m_cap = rd_iss;
        if (rd_iss) begin
            m_capd = m_peek(m_rda);
            m_rdp  = 0;
        end
        if (bus.cpu_cs && bus.cpu_we) mmem[int'(bus.cpu_addr)] = bus.cpu_wdata;
        if (wr_iss) begin
            mmem[int'(m_wq[0].a)] = m_wq[0].d;
            void'(m_wq.pop_front());
        end
        wreq = bus.hs_we && (!m_pwe || bus.hs_addr != m_pa || bus.hs_din != m_pd);
        rreq = !bus.hs_we && (bus.hs_addr != m_pa);
        if (wreq) begin
            if (m_wq.size() < WDEPTH) m_wq.push_back('{a: bus.hs_addr, d: bus.hs_din});
            else m_ovf = 1;
        end
        if (rreq) begin
            m_rdp = 1;
            m_rda = bus.hs_addr;
        end
        m_pwe = bus.hs_we; m_pa = bus.hs_addr; m_pd = bus.hs_din;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int n0, b0;
        reset_n = 1'b0;
        bus.hs_addr = '0; bus.hs_din = '0; bus.hs_we = 1'b0;
        bus.cpu_cs = 1'b0; bus.cpu_addr = 16'hFFFF; bus.cpu_wdata = '0; bus.cpu_we = 1'b0;
        model_reset();
        #12;
        chk("rst_dout", bus.hs_dout, 8'h00);
        chk("rst_busy", bus.hs_busy, 1'b0);
        chk("rst_ovf", bus.hs_ovf, 1'b0);
        chk("rst_ram_we", bus.ram_we, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Read with CPU idle: address at N+1, data at N+3
        bus.hs_addr = 16'h0123;
        tick();
        tick();
        chk("t1_ram_addr", o_addr, 16'h0123);
        tick();
        tick();
        chk("t1_dout", o_dout, 8'h5A);
        chk("t1_busy", o_busy, 1'b0);

        // Held write strobe yields one pulse
        n0 = bw_cyc.size();
        bus.hs_addr = 16'h0200; bus.hs_din = 8'hA5; bus.hs_we = 1'b1;
        repeat (10) tick();
        bus.hs_we = 1'b0;
        repeat (3) tick();
        chk("t2_pulses", bw_cyc.size() - n0, 1);
        chk("t2_ram", ram_peek(16'h0200), 8'hA5);

        // CPU owns RAM for 20 cycles, three writes arrive, third dropped
        n0 = bw_cyc.size();
        bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'hC3;
        for (int i = 0; i < 20; i++) begin
            bus.cpu_addr = 16'h0500 + 16'(i);
            if (i < 3) begin
                bus.hs_we = 1'b1;
                bus.hs_addr = 16'h0400 + 16'(i);
                bus.hs_din = 8'h11 * 8'(i + 1);
            end else begin
                bus.hs_we = 1'b0;
            end
            tick();
        end
        chk("t3_no_bridge_wr", bw_cyc.size() - n0, 0);
        chk("t3_ovf", o_ovf, 1'b1);
        chk("t3_busy", o_busy, 1'b1);
        bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'hFFFF;
        repeat (4) tick();
        chk("t3_pulses", bw_cyc.size() - n0, 2);
        if (bw_cyc.size() - n0 == 2) begin
            chk("t3_consecutive", bw_cyc[n0 + 1] - bw_cyc[n0], 1);
            chk("t3_first_addr", bw_addr[n0], 16'h0400);
            chk("t3_second_addr", bw_addr[n0 + 1], 16'h0401);
        end
        chk("t3_ram0", ram_peek(16'h0400), 8'h11);
        chk("t3_ram1", ram_peek(16'h0401), 8'h22);
        chk("t3_dropped", ram_peek(16'h0402), 8'h7E);
        chk("t3_cpu_wr", ram_peek(16'h0505), 8'hC3);

        // Write then read of the same address: write drains first
        b0 = br_cnt;
        bus.cpu_cs = 1'b1;
        bus.hs_we = 1'b1; bus.hs_addr = 16'h0300; bus.hs_din = 8'h77;
        tick();
        bus.hs_we = 1'b0; bus.hs_addr = 16'h0301;
        tick();
        bus.hs_addr = 16'h0300;
        tick();
        bus.cpu_cs = 1'b0;
        repeat (5) tick();
        chk("t4_reads", br_cnt - b0, 1);
        chk("t4_read_addr", br_last, 16'h0300);
        chk("t4_dout", o_dout, 8'h77);

        // Back-to-back reads while stalled: only the newest executes
        b0 = br_cnt;
        bus.cpu_cs = 1'b1;
        bus.hs_addr = 16'h0010; tick();
        bus.hs_addr = 16'h0011; tick();
        bus.hs_addr = 16'h0012; tick();
        bus.cpu_cs = 1'b0;
        repeat (5) tick();
        chk("t5_reads", br_cnt - b0, 1);
        chk("t5_read_addr", br_last, 16'h0012);
        chk("t5_dout", o_dout, 8'h6A);

        // Reset asserted during CAPTURE
        bus.hs_addr = 16'h0040;
        tick();
        tick();
        chk("t6_busy_before", bus.hs_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t6_dout", bus.hs_dout, 8'h00);
        chk("t6_busy", bus.hs_busy, 1'b0);
        chk("t6_ovf", bus.hs_ovf, 1'b0);
        chk("t6_ram_we", bus.ram_we, 1'b0);
        bus.hs_addr = '0; bus.hs_din = '0; bus.hs_we = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.cpu_cs    = ($urandom_range(0, 9) < 4);
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = 16'($urandom_range(0, 7));
            bus.cpu_wdata = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                bus.hs_we   = 1'($urandom_range(0, 1));
                bus.hs_addr = 16'($urandom_range(0, 7));
                bus.hs_din  = 8'($urandom_range(0, 3));
            end
            tick();
        end
        bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.hs_we = 1'b0;
        repeat (6) tick();
        for (int a = 0; a < 8; a++) begin
            chk("rand_ram", ram_peek(16'(a)), m_peek(16'(a)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hiscore_ram_bridge.md
# hiscore_ram_bridge

Slot-stealing bridge inside the game core between the high-score save/restore engine and the core's synchronous work RAM. The engine issues fire-and-forget reads (address changes) and writes (`hs_we`) with no handshake. The bridge buffers those requests and executes them only in cycles where the Z80 is not selecting the RAM. It returns read data on a held output and muxes the RAM port between CPU and engine.

## Interface
Parameters:
- `AW`, 16, RAM address width
- `WDEPTH`, 2, write buffer depth (power of two, ≥2)

Ports:
- `clk`  in  1  core clock (48 MHz domain)
- `reset_n`  in  1  asynchronous, active-low reset
- `hs_addr`  in  AW  engine address
- `hs_din`  in  8  engine write data
- `hs_we`  in  1  engine write strobe (level)
- `hs_dout`  out  8  last read result, held
- `hs_busy`  out  1  any request buffered or in flight
- `hs_ovf`  out  1  sticky: a write was dropped, buffer full
- `cpu_cs`  in  1  CPU selects RAM this cycle
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  8  CPU write data
- `cpu_we`  in  1  CPU write
- `ram_addr`  out  AW  to RAM
- `ram_wdata`  out  8  to RAM
- `ram_we`  out  1  to RAM
- `ram_rdata`  in  8  RAM output, valid 1 cycle after address

## Operation
- Reset: write FIFO empty, read pending clear, `hs_dout`=0, `hs_busy`=0, `hs_ovf`=0, last-seen addr/data/we registers = 0, state IDLE.
- Write request: cycle where `hs_we`=1 and (previous `hs_we`=0 or `hs_addr`/`hs_din` differ from previous cycle) → push {addr,data}. `hs_we` held with unchanged addr/data → no further push.
- FIFO full on push → drop the new entry, set `hs_ovf` (cleared only by reset).
- Read request: cycle where `hs_we`=0 and `hs_addr` differs from previous cycle → read pending with that address. A newer read request overwrites the pending address; only the newest read executes.
- Priority when slot free: FIFO head write > pending read. Writes drain first, so a read of a just-written address returns the new data.
- Slot free ⇔ `cpu_cs`=0, evaluated combinationally in the same cycle.
- Mux:
  - `cpu_cs`=1 → RAM port = CPU (`ram_we`=`cpu_we`), bridge stalls.
  - Otherwise RAM port = bridge request, with `ram_we`=1 only for a write issue.
  - Idle → `ram_addr`=`cpu_addr`, `ram_we`=0.
- States:
  - IDLE → ISSUE when anything is pending.
  - ISSUE: on a free slot, a write pops the head (stay in ISSUE if more are pending, else IDLE); a read → CAPTURE.
  - CAPTURE: `hs_dout` ← `ram_rdata` → IDLE or ISSUE. CAPTURE does not use the RAM port; the CPU may take it.
- `hs_busy` = FIFO non-empty | read pending | state≠IDLE.
- `reset_n` asserted mid-operation → everything cleared immediately. An in-flight read result is discarded; `hs_dout`=0.

## Timing
- Request detect registered. A request presented in cycle N is eligible for issue in cycle N+1.
- Write: `ram_we`=1 in the first free cycle ≥ N+1, for exactly one cycle.
- Read: address driven in the first free cycle F ≥ N+1. `hs_dout` is updated at the end of F+1 and visible from F+2. With the CPU idle, this is N+3.
- A read request arriving during CAPTURE is queued and does not corrupt the capture.
- Simultaneous write push and FIFO pop in one cycle → both occur; occupancy is unchanged; no overflow even when full.
- `cpu_cs` held high indefinitely → no bridge RAM access; requests remain buffered; `hs_busy`=1.

## Test plan
- CPU idle, `hs_addr`=0x0123 (RAM[0x0123]=0x5A) → `ram_addr`=0x0123 at N+1, `hs_dout`=0x5A at N+3, `hs_busy` low at N+3.
- `hs_we`=1 with addr 0x0200, data 0xA5 held 10 cycles → exactly one `ram_we` pulse; RAM[0x0200]=0xA5.
- `cpu_cs`=1 for 20 cycles while three distinct writes arrive → third write dropped, `hs_ovf`=1. After `cpu_cs` falls: two `ram_we` pulses in consecutive cycles, in arrival order; CPU accesses untouched.
- Write 0x77 to 0x0300 immediately followed by a read of 0x0300 → write issues before the read; `hs_dout`=0x77.
- Reads of 0x0010, 0x0011, 0x0012 on consecutive cycles with `cpu_cs`=1 → after release, a single read of 0x0012 executes.
- `reset_n` low during CAPTURE → `hs_dout`=0, `hs_busy`=0, `hs_ovf`=0, `ram_we`=0 immediately.
